// File: rtl/wash_pkg.sv
// Shared constants and helpers for the washing-machine plant model.
// Default sizing, fault-bit positions and valve-command decoding.
package wash_pkg;

  localparam int LEVEL_W_DEF      = 8;
  localparam int LEVEL_FULL_DEF   = 200;
  localparam int LEVEL_MAX_DEF    = 255;
  localparam int FILL_RATE_DEF    = 1;
  localparam int DRAIN_RATE_DEF   = 2;
  localparam int TMR_W_DEF        = 16;
  localparam int DET_CYCLES_DEF   = 20;
  localparam int CYCLE_CYCLES_DEF = 1000;
  localparam int SPIN_CYCLES_DEF  = 500;

  localparam int FAULT_W  = 3;
  localparam int FLT_OVF  = 0;
  localparam int FLT_CONF = 1;
  localparam int FLT_DOOR = 2;

  typedef enum logic [1:0] {
    LVL_HOLD,
    LVL_FILL,
    LVL_DRAIN,
    LVL_CONFLICT
  } level_op_e;

  // Both valves open at once is treated as a conflict and leaves the level alone.
  function automatic level_op_e decode_level_op(input logic fill, input logic drain);
    level_op_e op;
    case ({fill, drain})
      2'b10:   op = LVL_FILL;
      2'b01:   op = LVL_DRAIN;
      2'b11:   op = LVL_CONFLICT;
      default: op = LVL_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/wash_plant_model_if.sv
// Controller <-> plant bundle: actuator commands one way, sensor readings the other.
interface wash_plant_model_if #(
  parameter int LEVEL_W = 8
) ();

  logic               fill_value_on;
  logic               drain_value_on;
  logic               motor_on;
  logic               door_lock;
  logic               soap_wash;
  logic               filled;
  logic               drained;
  logic               detergent_added;
  logic               cycle_timeout;
  logic               spin_timeout;
  logic [LEVEL_W-1:0] water_level;
  logic [2:0]         fault;

  modport master (
    output fill_value_on, drain_value_on, motor_on, door_lock, soap_wash,
    input  filled, drained, detergent_added, cycle_timeout, spin_timeout, water_level, fault
  );

  modport slave (
    input  fill_value_on, drain_value_on, motor_on, door_lock, soap_wash,
    output filled, drained, detergent_added, cycle_timeout, spin_timeout, water_level, fault
  );

endinterface

// File: rtl/wash_timer.sv
// Terminal-count timer: counts enabled clocks and emits a one-clock done pulse
// after TERM of them, then starts over. Clear always beats a pending pulse.
module wash_timer #(
  parameter int TMR_W = 16,
  parameter int TERM  = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic done
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TERM - 1);
  localparam logic [TMR_W-1:0] ONE  = TMR_W'(1);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
      done  <= 1'b0;
    end else if (en) begin
      if (count == LAST) begin
        count <= '0;
        done  <= 1'b1;
      end else begin
        count <= count + ONE;
        done  <= 1'b0;
      end
    end else begin
      count <= '0;
      done  <= 1'b0;
    end
  end

endmodule

// File: rtl/wash_plant_model.sv
// Plant/sensor model that closes the loop around the washing-machine controller:
// integrates the tank level, times detergent, wash and spin, and logs sticky faults.
module wash_plant_model
  import wash_pkg::*;
#(
  parameter int LEVEL_W      = LEVEL_W_DEF,
  parameter int LEVEL_FULL   = LEVEL_FULL_DEF,
  parameter int LEVEL_MAX    = LEVEL_MAX_DEF,
  parameter int FILL_RATE    = FILL_RATE_DEF,
  parameter int DRAIN_RATE   = DRAIN_RATE_DEF,
  parameter int TMR_W        = TMR_W_DEF,
  parameter int DET_CYCLES   = DET_CYCLES_DEF,
  parameter int CYCLE_CYCLES = CYCLE_CYCLES_DEF,
  parameter int SPIN_CYCLES  = SPIN_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  wash_plant_model_if.slave  plant
);

  localparam logic [LEVEL_W:0]   FILL_INC   = (LEVEL_W + 1)'(FILL_RATE);
  localparam logic [LEVEL_W:0]   LEVEL_CEIL = (LEVEL_W + 1)'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] DRAIN_DEC  = LEVEL_W'(DRAIN_RATE);
  localparam logic [LEVEL_W-1:0] FULL_MARK  = LEVEL_W'(LEVEL_FULL);

  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] level_next;
  logic [LEVEL_W:0]   fill_sum;
  logic               fill_over;
  level_op_e          level_op;

  logic [FAULT_W-1:0] fault_q;
  logic [FAULT_W-1:0] fault_set;

  logic soap_q;
  logic soap_rise;
  logic det_done;
  logic det_hold;
  logic cycle_done;
  logic spin_done;
  logic spin_qual;

  // The sum is one bit wider than the level so an overshoot past LEVEL_MAX is visible.
  always_comb begin
    level_op   = decode_level_op(plant.fill_value_on, plant.drain_value_on);
    fill_sum   = {1'b0, level} + FILL_INC;
    fill_over  = (fill_sum > LEVEL_CEIL);
    level_next = level;
    case (level_op)
      LVL_FILL:  level_next = fill_over ? LEVEL_TOP : fill_sum[LEVEL_W-1:0];
      LVL_DRAIN: level_next = (level < DRAIN_DEC) ? '0 : (level - DRAIN_DEC);
      default:   level_next = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
    end else begin
      level <= level_next;
    end
  end

  always_comb begin
    fault_set           = '0;
    fault_set[FLT_OVF]  = plant.fill_value_on & fill_over;
    fault_set[FLT_CONF] = (level_op == LVL_CONFLICT);
    fault_set[FLT_DOOR] = ~plant.door_lock &
                          (plant.fill_value_on | plant.drain_value_on | plant.motor_on);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= '0;
    end else begin
      fault_q <= fault_q | fault_set;
    end
  end

  assign soap_rise = plant.soap_wash & ~soap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      soap_q <= 1'b0;
    end else begin
      soap_q <= plant.soap_wash;
    end
  end

  wash_timer #(
    .TMR_W (TMR_W),
    .TERM  (DET_CYCLES)
  ) u_det_timer (
    .clk   (clk),
    .reset (reset),
    .en    (plant.soap_wash),
    .clr   (~plant.soap_wash | soap_rise),
    .done  (det_done)
  );

  // The det timer keeps wrapping while soap is held, so latch its first pulse into a level.
  always_ff @(posedge clk) begin
    if (reset || !plant.soap_wash || soap_rise) begin
      det_hold <= 1'b0;
    end else if (det_done) begin
      det_hold <= 1'b1;
    end
  end

  wash_timer #(
    .TMR_W (TMR_W),
    .TERM  (CYCLE_CYCLES)
  ) u_cycle_timer (
    .clk   (clk),
    .reset (reset),
    .en    (plant.motor_on),
    .clr   (~plant.motor_on),
    .done  (cycle_done)
  );

  assign spin_qual = plant.drain_value_on & (level == '0);

  wash_timer #(
    .TMR_W (TMR_W),
    .TERM  (SPIN_CYCLES)
  ) u_spin_timer (
    .clk   (clk),
    .reset (reset),
    .en    (spin_qual),
    .clr   (~spin_qual),
    .done  (spin_done)
  );

  // Every sensor is a decode of registered state, so the controller sees no combinational path.
  assign plant.filled          = (level >= FULL_MARK);
  assign plant.drained         = (level == '0);
  assign plant.detergent_added = det_hold | det_done;
  assign plant.cycle_timeout   = cycle_done;
  assign plant.spin_timeout    = spin_done;
  assign plant.water_level     = level;
  assign plant.fault           = fault_q;

endmodule

// File: tb/tb_wash_plant_model.sv
// Directed bench for wash_plant_model: stimulus queues hand-computed expected sensor
// snapshots, a negedge monitor pops and compares them on the cycle they are due.
module tb_wash_plant_model;

  localparam int LEVEL_W = 8;

  typedef struct {
    string       name;
    int          cyc;
    logic [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   check_count = 0;
  int   pass_count = 0;
  exp_t sb_q[$];

  wash_plant_model_if #(.LEVEL_W(LEVEL_W)) bus ();

  wash_plant_model #(
    .LEVEL_W      (LEVEL_W),
    .LEVEL_FULL   (10),
    .LEVEL_MAX    (12),
    .FILL_RATE    (1),
    .DRAIN_RATE   (2),
    .TMR_W        (16),
    .DET_CYCLES   (3),
    .CYCLE_CYCLES (5),
    .SPIN_CYCLES  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .plant (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Packs {level, filled, drained, detergent_added, cycle_timeout, spin_timeout, fault}.
  function automatic logic [15:0] ex(input int lvl, input bit fil, input bit drn, input bit det,
                                     input bit cto, input bit sto, input bit [2:0] flt);
    logic [7:0] l8;
    l8 = lvl[7:0];
    return {l8, fil, drn, det, cto, sto, flt};
  endfunction

  task automatic apply_stimulus(input string name, input bit rst, input bit fill, input bit drain,
                                input bit motor, input bit lock, input bit soap,
                                input bit chk, input logic [15:0] expv);
    exp_t e;
    if (chk) begin
      e.name = name;
      e.cyc  = cyc + 1;
      e.val  = expv;
      sb_q.push_back(e);
    end
    reset              = rst;
    bus.fill_value_on  = fill;
    bus.drain_value_on = drain;
    bus.motor_on       = motor;
    bus.door_lock      = lock;
    bus.soap_wash      = soap;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n, input bit fill, input bit drain, input bit motor,
                            input bit soap);
    for (int i = 0; i < n; i++) apply_stimulus("idle", 1'b0, fill, drain, motor, 1'b1, soap, 1'b0, '0);
  endtask

  task automatic check_output(input exp_t e, input logic [15:0] act);
    check_count++;
    if (e.cyc == cyc && act === e.val) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s @cyc %0d (due %0d): got lvl=%0d fil/drn/det/cto/sto=%b fault=%b, expected lvl=%0d fil/drn/det/cto/sto=%b fault=%b",
               e.name, cyc, e.cyc, act[15:8], act[7:3], act[2:0], e.val[15:8], e.val[7:3], e.val[2:0]);
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e   = sb_q.pop_front();
      act = {bus.water_level, bus.filled, bus.drained, bus.detergent_added,
             bus.cycle_timeout, bus.spin_timeout, bus.fault};
      check_output(e, act);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    bus.fill_value_on  = 1'b0;
    bus.drain_value_on = 1'b0;
    bus.motor_on       = 1'b0;
    bus.door_lock      = 1'b1;
    bus.soap_wash      = 1'b0;

    apply_stimulus("rst_state", 1, 0, 0, 0, 1, 0, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));

    // Fill from empty: filled on the 10th clock, overflow on the 13th.
    idle_steps(8, 1, 0, 0, 0);
    apply_stimulus("fill_9",     0, 1, 0, 0, 1, 0, 1, ex(9,  0, 0, 0, 0, 0, 3'b000));
    apply_stimulus("fill_full",  0, 1, 0, 0, 1, 0, 1, ex(10, 1, 0, 0, 0, 0, 3'b000));
    apply_stimulus("fill_11",    0, 1, 0, 0, 1, 0, 1, ex(11, 1, 0, 0, 0, 0, 3'b000));
    apply_stimulus("fill_max",   0, 1, 0, 0, 1, 0, 1, ex(12, 1, 0, 0, 0, 0, 3'b000));
    apply_stimulus("fill_ovf",   0, 1, 0, 0, 1, 0, 1, ex(12, 1, 0, 0, 0, 0, 3'b001));
    apply_stimulus("ovf_sticky", 0, 0, 0, 0, 1, 0, 1, ex(12, 1, 0, 0, 0, 0, 3'b001));
    apply_stimulus("rst_clear",  1, 0, 0, 0, 1, 0, 1, ex(0,  0, 1, 0, 0, 0, 3'b000));

    // Drain from 11 by twos, saturating at 0.
    idle_steps(10, 1, 0, 0, 0);
    apply_stimulus("fill_to_11", 0, 1, 0, 0, 1, 0, 1, ex(11, 1, 0, 0, 0, 0, 3'b000));
    apply_stimulus("drain_9",    0, 0, 1, 0, 1, 0, 1, ex(9,  0, 0, 0, 0, 0, 3'b000));
    idle_steps(3, 0, 1, 0, 0);
    apply_stimulus("drain_1",    0, 0, 1, 0, 1, 0, 1, ex(1,  0, 0, 0, 0, 0, 3'b000));
    apply_stimulus("drain_0",    0, 0, 1, 0, 1, 0, 1, ex(0,  0, 1, 0, 0, 0, 3'b000));

    // Draining an empty tank qualifies the spin timer.
    idle_steps(2, 0, 1, 0, 0);
    apply_stimulus("no_wrap",    0, 0, 1, 0, 1, 0, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));
    apply_stimulus("spin_pulse", 0, 0, 1, 0, 1, 0, 1, ex(0, 0, 1, 0, 0, 1, 3'b000));
    apply_stimulus("spin_once",  0, 0, 1, 0, 1, 0, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));
    idle_steps(1, 0, 0, 0, 0);

    // Reset during a spin count aborts it; the count restarts from zero.
    idle_steps(1, 0, 1, 0, 0);
    apply_stimulus("spin_rst",       1, 0, 1, 0, 1, 0, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));
    apply_stimulus("spin_after_rst", 0, 0, 1, 0, 1, 0, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));
    idle_steps(1, 0, 1, 0, 0);
    apply_stimulus("spin_restart_3", 0, 0, 1, 0, 1, 0, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));
    apply_stimulus("spin_restart_p", 0, 0, 1, 0, 1, 0, 1, ex(0, 0, 1, 0, 0, 1, 3'b000));
    idle_steps(1, 0, 0, 0, 0);

    // Detergent: flag three clocks after the soap edge, held, cleared, restartable.
    idle_steps(2, 0, 0, 0, 1);
    apply_stimulus("det_pending",  0, 0, 0, 0, 1, 1, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));
    apply_stimulus("det_added",    0, 0, 0, 0, 1, 1, 1, ex(0, 0, 1, 1, 0, 0, 3'b000));
    idle_steps(2, 0, 0, 0, 1);
    apply_stimulus("det_hold",     0, 0, 0, 0, 1, 1, 1, ex(0, 0, 1, 1, 0, 0, 3'b000));
    apply_stimulus("det_clear",    0, 0, 0, 0, 1, 0, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));
    idle_steps(2, 0, 0, 0, 1);
    apply_stimulus("det_re_wait",  0, 0, 0, 0, 1, 1, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));
    apply_stimulus("det_restart",  0, 0, 0, 0, 1, 1, 1, ex(0, 0, 1, 1, 0, 0, 3'b000));
    idle_steps(1, 0, 0, 0, 0);

    // Cycle timer: a single pulse after five motor clocks, none if aborted.
    idle_steps(3, 0, 0, 1, 0);
    apply_stimulus("cyc_pending",  0, 0, 0, 1, 1, 0, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));
    apply_stimulus("cyc_pulse",    0, 0, 0, 1, 1, 0, 1, ex(0, 0, 1, 0, 1, 0, 3'b000));
    apply_stimulus("cyc_single",   0, 0, 0, 0, 1, 0, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));
    idle_steps(3, 0, 0, 1, 0);
    apply_stimulus("cyc_abort",    0, 0, 0, 0, 1, 0, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));
    apply_stimulus("cyc_re_1",     0, 0, 0, 1, 1, 0, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));
    idle_steps(2, 0, 0, 1, 0);
    apply_stimulus("cyc_re_4",     0, 0, 0, 1, 1, 0, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));
    apply_stimulus("cyc_re_pulse", 0, 0, 0, 1, 1, 0, 1, ex(0, 0, 1, 0, 1, 0, 3'b000));
    idle_steps(1, 0, 0, 0, 0);

    // Valve conflict and unlocked door: level holds, faults stick until reset.
    idle_steps(1, 1, 0, 0, 0);
    apply_stimulus("fill_to_2",       0, 1, 0, 0, 1, 0, 1, ex(2, 0, 0, 0, 0, 0, 3'b000));
    apply_stimulus("conflict_hold",   0, 1, 1, 0, 1, 0, 1, ex(2, 0, 0, 0, 0, 0, 3'b010));
    idle_steps(1, 1, 1, 0, 0);
    apply_stimulus("conflict_sticky", 0, 0, 0, 0, 1, 0, 1, ex(2, 0, 0, 0, 0, 0, 3'b010));
    apply_stimulus("door_err",        0, 0, 0, 1, 0, 0, 1, ex(2, 0, 0, 0, 0, 0, 3'b110));
    apply_stimulus("door_sticky",     0, 0, 0, 0, 1, 0, 1, ex(2, 0, 0, 0, 0, 0, 3'b110));
    apply_stimulus("rst_final",       1, 0, 0, 0, 1, 0, 1, ex(0, 0, 1, 0, 0, 0, 3'b000));

    idle_steps(2, 0, 0, 0, 0);

    check_count++;
    if (sb_q.size() == 0) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL sb_drain: %0d expectations left unchecked, required 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
